// File: rtl/div_if.sv
// div_if: request/response bundle between the EX-stage decoder side and div_unit.
//   master: drives div_valid, div_op, dividend, divisor, flush; observes status/result.
//   slave : the divider; drives div_ready, div_busy, res_valid, div_out.
interface div_if #(
  parameter int WIDTH = 32
);
  logic             div_valid;
  logic [1:0]       div_op;     // 0=DIV 1=DIVU 2=REM 3=REMU
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             flush;
  logic             div_ready;
  logic             div_busy;
  logic             res_valid;
  logic [WIDTH-1:0] div_out;

  modport master (
    output div_valid, div_op, dividend, divisor, flush,
    input  div_ready, div_busy, res_valid, div_out
  );

  modport slave (
    input  div_valid, div_op, dividend, divisor, flush,
    output div_ready, div_busy, res_valid, div_out
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle RV32M DIV/DIVU/REM/REMU, radix-2 restoring, one quotient
// bit per clock. Divide-by-zero and signed MIN/-1 bypass the iteration loop.
// Ports:
//   clk   - rising-edge clock
//   nrst  - asynchronous active-low reset
//   bus   - div_if.slave: request (div_valid/div_op/dividend/divisor/flush),
//           status (div_ready/div_busy), result (res_valid pulse, div_out held).
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic nrst,
  div_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rem_sel_q, rem_sel_d;   // 1: return remainder
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;           // holds |dividend| and shifts in quotient bits
  logic [WIDTH-1:0] dvsr_q, dvsr_d;         // |divisor|
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] out_q, out_d;

  // operand prep for the request currently on the bus
  logic             is_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  // one restoring step
  logic [WIDTH:0]   sh, trial;
  logic [WIDTH-1:0] quo_nx, rem_nx, q_fix, r_fix;

  always_comb begin
    is_signed = ~bus.div_op[0];
    a_neg     = is_signed & bus.dividend[WIDTH-1];
    b_neg     = is_signed & bus.divisor[WIDTH-1];
    a_mag     = a_neg ? -bus.dividend : bus.dividend;
    b_mag     = b_neg ? -bus.divisor  : bus.divisor;

    // Partial remainder is always < divisor, so the shifted value needs one
    // extra bit and the signed difference fits in WIDTH+1 bits.
    sh     = {rem_q, quo_q[WIDTH-1]};
    trial  = sh - {1'b0, dvsr_q};
    quo_nx = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    rem_nx = trial[WIDTH] ? sh[WIDTH-1:0] : trial[WIDTH-1:0];
    q_fix  = negq_q ? -quo_nx : quo_nx;
    r_fix  = negr_q ? -rem_nx : rem_nx;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_sel_d = rem_sel_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    out_d     = out_q;

    unique case (state_q)
      IDLE: begin
        if (bus.div_valid && !bus.flush) begin
          rem_sel_d = bus.div_op[1];
          if (bus.divisor == '0) begin
            out_d   = bus.div_op[1] ? bus.dividend : '1;
            state_d = DONE;
          end else if (is_signed && bus.dividend == MIN_NEG && bus.divisor == '1) begin
            out_d   = bus.div_op[1] ? '0 : MIN_NEG;
            state_d = DONE;
          end else begin
            rem_d   = '0;
            quo_d   = a_mag;
            dvsr_d  = b_mag;
            negq_d  = a_neg ^ b_neg;
            negr_d  = a_neg;
            cnt_d   = CW'(WIDTH-1);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          // last step: sign-fixed result goes straight into the output register
          cnt_d   = '0;
          out_d   = rem_sel_q ? r_fix : q_fix;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // abort wins over everything; the held result is left untouched
    if (bus.flush) begin
      state_d = IDLE;
      out_d   = out_q;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_sel_q <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_sel_q <= rem_sel_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      negq_q    <= negq_d;
      negr_q    <= negr_d;
      out_q     <= out_d;
    end
  end

  assign bus.div_ready = (state_q == IDLE);
  assign bus.div_busy  = (state_q == CALC);
  assign bus.res_valid = (state_q == DONE);
  assign bus.div_out   = out_q;

endmodule
